ff_excitation_seq: RTL and testbench



---
 rtl/ff_excitation_seq_if.sv | 25 ++
 rtl/ff_excitation_seq.sv | 116 +++++++++++
 tb/tb_ff_excitation_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ff_excitation_seq_if.sv
// Target-word handshake between a stimulus source and the excitation sequencer.
// The master offers a target next-state word plus a fault-inject flag.
// The slave accepts the word while in_ready is high.
interface ff_excitation_seq_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] target;
    logic             inject;

    modport master (
        output in_valid,
        output target,
        output inject,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  target,
        input  inject,
        output in_ready
    );
endinterface

// File: rtl/ff_excitation_seq.sv
// Excitation-table sequencer: converts each accepted target next-state word
// into S/R, J/K, D and T excitations for four parallel flip-flop banks.
// It clocks the banks from their own present state, then checks that every
// bank reached the target.
// Banks are never forced to the target, so an injected T-bank fault stays in
// q_t until a later excitation, computed from the real q_t, corrects it.
module ff_excitation_seq #(
    parameter int WIDTH = 4,
    parameter int ERRW  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    ff_excitation_seq_if.slave     bus,
    output logic [WIDTH-1:0]       q_sr,
    output logic [WIDTH-1:0]       q_jk,
    output logic [WIDTH-1:0]       q_d,
    output logic [WIDTH-1:0]       q_t,
    output logic                   done,
    output logic                   match,
    output logic [ERRW-1:0]        err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXC  = 2'd1,
        UPD  = 2'd2,
        CHK  = 2'd3
    } state_t;

    state_t           state;
    logic             in_ready_r;
    logic [WIDTH-1:0] tgt;
    logic             inj;

    // Excitation registers, loaded in EXC and consumed in UPD.
    logic [WIDTH-1:0] ex_s, ex_r, ex_j, ex_k, ex_d, ex_t;

    // Fault mask: only the T bank bit 0 is ever disturbed.
    logic [WIDTH-1:0] inj_mask;
    logic             all_match;

    assign inj_mask     = {{(WIDTH-1){1'b0}}, inj};
    assign all_match    = (q_sr == tgt) && (q_jk == tgt) && (q_d == tgt) && (q_t == tgt);
    assign bus.in_ready = in_ready_r;

    // Sequencer FSM: capture, excite, clock the banks, then check and report.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            in_ready_r <= 1'b1;
            tgt        <= '0;
            inj        <= 1'b0;
            ex_s       <= '0;
            ex_r       <= '0;
            ex_j       <= '0;
            ex_k       <= '0;
            ex_d       <= '0;
            ex_t       <= '0;
            q_sr       <= '0;
            q_jk       <= '0;
            q_d        <= '0;
            q_t        <= '0;
            done       <= 1'b0;
            match      <= 1'b0;
            err_count  <= '0;
        end else begin
            // NOTE: non-blocking assignments let every branch read the
            // pre-edge values of q_* and the excitation registers, which is
            // what makes EXC and UPD behave as separate clocked stages.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        tgt        <= bus.target;
                        inj        <= bus.inject;
                        in_ready_r <= 1'b0;
                        state      <= EXC;
                    end
                end
                EXC: begin
                    // Don't-cares resolve to 0, so S&R and J&K stay 0.
                    ex_s  <= ~q_sr & tgt;
                    ex_r  <=  q_sr & ~tgt;
                    ex_j  <= ~q_jk & tgt;
                    ex_k  <=  q_jk & ~tgt;
                    ex_d  <= tgt;
                    ex_t  <= (q_t ^ tgt) ^ inj_mask;
                    state <= UPD;
                end
                UPD: begin
                    q_sr  <= ex_s | (q_sr & ~ex_r);
                    q_jk  <= (ex_j & ~q_jk) | (~ex_k & q_jk);
                    q_d   <= ex_d;
                    q_t   <= q_t ^ ex_t;
                    state <= CHK;
                end
                CHK: begin
                    done  <= 1'b1;
                    match <= all_match;
                    if (!all_match && (err_count != {ERRW{1'b1}})) begin
                        err_count <= err_count + 1'b1;
                    end
                    in_ready_r <= 1'b1;
                    state      <= IDLE;
                end
                // NOTE: the default arm keeps the case complete, so no
                // encoding can leave the FSM stuck or imply unintended hold logic.
                default: begin
                    in_ready_r <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ff_excitation_seq.sv
// Directed self-checking bench for ff_excitation_seq.
module tb_ff_excitation_seq;

    localparam int WIDTH = 4;
    localparam int ERRW  = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] q_sr, q_jk, q_d, q_t;
    logic             done, match;
    logic [ERRW-1:0]  err_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ff_excitation_seq_if #(.WIDTH(WIDTH)) bus ();

    ff_excitation_seq #(.WIDTH(WIDTH), .ERRW(ERRW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .q_sr      (q_sr),
        .q_jk      (q_jk),
        .q_d       (q_d),
        .q_t       (q_t),
        .done      (done),
        .match     (match),
        .err_count (err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Bounded wait (called at a negedge) for the block to become ready.
    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    // Offer one word and check it through the full 4-cycle pipeline.
    task automatic send_word(input string tag, input logic [3:0] tgt, input logic inj,
                             input logic [3:0] exp_qt, input logic exp_match,
                             input logic [7:0] exp_err);
        wait_ready(tag);
        bus.target   = tgt;
        bus.inject   = inj;
        bus.in_valid = 1'b1;
        @(posedge clk);                     // E0: accept
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.inject   = ~inj;                // must not matter after accept
        bus.target   = ~tgt;
        check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        @(posedge clk);                     // E1: excitations load
        @(posedge clk);                     // E2: banks clock
        @(negedge clk);
        bus.inject = 1'b0;
        check({tag, "_q_sr"}, 32'(q_sr), 32'(tgt));
        check({tag, "_q_jk"}, 32'(q_jk), 32'(tgt));
        check({tag, "_q_d"},  32'(q_d),  32'(tgt));
        check({tag, "_q_t"},  32'(q_t),  32'(exp_qt));
        check({tag, "_early_done"}, 32'(done), 32'd0);
        @(posedge clk);                     // E3: report
        @(negedge clk);
        check({tag, "_done"},  32'(done),  32'd1);
        check({tag, "_match"}, 32'(match), 32'(exp_match));
        check({tag, "_err"},   32'(err_count), 32'(exp_err));
        check({tag, "_rdy_at_done"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq [5];
        logic [3:0] tgt;
        logic [7:0] exp_err;

        seq = '{4'b1010, 4'b0101, 4'b1111, 4'b0000, 4'b0000};

        bus.in_valid = 1'b0;
        bus.target   = '0;
        bus.inject   = 1'b0;
        reset        = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Idle state after reset.
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_q_sr",  32'(q_sr), 32'd0);
        check("rst_q_jk",  32'(q_jk), 32'd0);
        check("rst_q_d",   32'(q_d),  32'd0);
        check("rst_q_t",   32'(q_t),  32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_match", 32'(match), 32'd0);
        check("rst_err",   32'(err_count), 32'd0);

        // First word from reset.
        send_word("w1010", 4'b1010, 1'b0, 4'b1010, 1'b1, 8'd0);

        // Back-to-back words with in_valid held high: one accept every 4 cycles.
        bus.in_valid = 1'b1;
        for (int w = 0; w < 5; w++) begin
            bus.target = seq[w];
            check("b2b_rdy", 32'(bus.in_ready), 32'd1);
            @(posedge clk);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check("b2b_busy", 32'(bus.in_ready), 32'd0);
                check("b2b_nodone", 32'(done), 32'd0);
                @(posedge clk);
            end
            @(negedge clk);
            check("b2b_done",  32'(done),  32'd1);
            check("b2b_match", 32'(match), 32'd1);
            check("b2b_err",   32'(err_count), 32'd0);
            check("b2b_q_sr",  32'(q_sr), 32'(seq[w]));
            check("b2b_q_jk",  32'(q_jk), 32'(seq[w]));
            check("b2b_q_t",   32'(q_t),  32'(seq[w]));
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("done_pulse_len", 32'(done), 32'd0);

        // Injected fault leaves q_t behind, the next clean word heals it.
        send_word("inject", 4'b0001, 1'b1, 4'b0000, 1'b0, 8'd1);
        send_word("heal",   4'b0001, 1'b0, 4'b0001, 1'b1, 8'd1);

        // Saturation: 2^ERRW+3 faulty words, alternating targets.
        exp_err = 8'd1;
        for (int i = 0; i < (1 << ERRW) + 3; i++) begin
            tgt = i[0] ? 4'hA : 4'h5;
            if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
            send_word("sat", tgt, 1'b1, tgt ^ 4'b0001, 1'b0, exp_err);
        end
        check("sat_final", 32'(err_count), 32'hFF);

        // Reset during UPD of a 1111 word aborts it.
        wait_ready("abort");
        bus.target   = 4'b1111;
        bus.inject   = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);                     // E0
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);                     // E1: now in UPD
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_q_sr",  32'(q_sr), 32'd0);
        check("abort_q_jk",  32'(q_jk), 32'd0);
        check("abort_q_d",   32'(q_d),  32'd0);
        check("abort_q_t",   32'(q_t),  32'd0);
        check("abort_ready", 32'(bus.in_ready), 32'd1);
        check("abort_done",  32'(done), 32'd0);
        check("abort_err",   32'(err_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        send_word("post", 4'b0011, 1'b0, 4'b0011, 1'b1, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
